// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        PAR   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int GAP_LEN_DEF = 2;

    // A length of 0, or one longer than the register, means "use the full register".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned pat_w);
        return ((len == 0) || (len > pat_w)) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable pattern register with a bit-index down-counter.
// bit_nx is the bit that will be on the line after this edge, so the
// top level can register x_out without an extra cycle of latency.
// Optional macro SEQ_TX_PARITY_EN adds an even-parity output over the active bits.
module seq_tx_shreg #(
    parameter int PAT_W = 8,
    parameter int LW    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_d,
    input  logic [LW-1:0]    len_d,
    input  logic             dec,
    input  logic             reload,
    output logic             bit_nx,
    output logic             last
`ifdef SEQ_TX_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int IDX_W = $clog2(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_nx;
    logic [LW-1:0]    len_q, len_nx, len_m1;
    logic [IDX_W-1:0] idx_q, idx_nx;

    // Next-state selection: a load or reload restarts at the MSB of the frame.
    always_comb begin
        pat_nx = load ? pat_d : pat_q;
        len_nx = load ? len_d : len_q;
        len_m1 = len_nx - 1'b1;
        if (load || reload)
            idx_nx = IDX_W'(len_m1);
        else if (dec)
            idx_nx = idx_q - 1'b1;
        else
            idx_nx = idx_q;
        bit_nx = pat_nx[idx_nx];
    end

    assign last = (idx_q == '0);

    // Pattern, length and index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_nx;
            len_q <= len_nx;
            idx_q <= idx_nx;
        end
    end

`ifdef SEQ_TX_PARITY_EN
    // Even parity over the low len_q bits only.
    always_comb begin
        parity = 1'b0;
        for (int i = 0; i < PAT_W; i++)
            if (i < int'(len_q))
                parity = parity ^ pat_q[i];
    end
`endif

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial stimulus transmitter: sends a latched pattern MSB-first, rep+1
// times with GAP_LEN idle cycles between frames, then pulses done.
// Optional macro SEQ_TX_PARITY_EN appends an even-parity bit to each frame.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W   = 8,
    parameter int CNT_W   = 4,
    parameter int GAP_LEN = GAP_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [PAT_W-1:0]           pat_in,
    input  logic [$clog2(PAT_W+1)-1:0] len_in,
    input  logic [CNT_W-1:0]           rep_in,
    output logic                       x_out,
    output logic                       x_vld,
    output logic                       busy,
    output logic                       done
);

    localparam int LW = $clog2(PAT_W + 1);
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [LW-1:0]    len_eff;
    logic             load, dec, reload, frame_end;
    logic             bit_nx, last;
    logic             x_out_d, x_vld_d;
`ifdef SEQ_TX_PARITY_EN
    logic             parity;
`endif

    assign len_eff     = LW'(eff_len(32'(len_in), PAT_W));
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == SHIFT) || (state_q == GAP) || (state_q == PAR);

    seq_tx_shreg #(.PAT_W(PAT_W), .LW(LW)) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .pat_d  (pat_in),
        .len_d  (len_eff),
        .dec    (dec),
        .reload (reload),
        .bit_nx (bit_nx),
        .last   (last)
`ifdef SEQ_TX_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    // Next-state logic; frame_end funnels the repeat/gap/done decision into one place.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        load      = 1'b0;
        dec       = 1'b0;
        reload    = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                    rep_d   = rep_in;
                end
            end
            SHIFT: begin
                if (!last)
                    dec = 1'b1;
                else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = PAR;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: frame_end = 1'b1;
`endif
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SHIFT;
                    reload  = 1'b1;
                end else
                    gap_d = gap_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Repeat counter only counts down to zero, so all-ones never wraps.
        if (frame_end) begin
            if (rep_q != '0) begin
                rep_d = rep_q - 1'b1;
                if (GAP_LEN > 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = SHIFT;
                    reload  = 1'b1;
                end
            end else
                state_d = DONE;
        end
    end

    // Line values for the cycle entered by the next edge.
    always_comb begin
        x_out_d = 1'b0;
        x_vld_d = 1'b0;
        if (state_d == SHIFT) begin
            x_out_d = bit_nx;
            x_vld_d = 1'b1;
        end
`ifdef SEQ_TX_PARITY_EN
        else if (state_d == PAR) begin
            x_out_d = parity;
            x_vld_d = 1'b1;
        end
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rep_q   <= '0;
            gap_q   <= '0;
            x_out   <= 1'b0;
            x_vld   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            x_out   <= x_out_d;
            x_vld   <= x_vld_d;
            done    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx (PAT_W=8, CNT_W=4, GAP_LEN=2).
module tb_seq_pattern_tx;

    localparam int GAP = 2;

    logic       clk, rst;
    logic       start_valid, start_ready;
    logic [7:0] pat_in;
    logic [3:0] len_in, rep_in;
    logic       x_out, x_vld, busy, done;

    int tests = 0;
    int fails = 0;

    // Expected per-cycle tuple {x_vld, x_out, done, busy, start_ready}.
    logic [4:0] sb[$];

    seq_pattern_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pat_in      (pat_in),
        .len_in      (len_in),
        .rep_in      (rep_in),
        .x_out       (x_out),
        .x_vld       (x_vld),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic v, input logic x, input logic d,
                                 input logic b, input logic r);
        sb.push_back({v, x, d, b, r});
    endfunction

    // Expected stream from the cycle after acceptance through the done pulse.
    function automatic void push_frame(input logic [7:0] pat, input int len, input int rep);
        int   l;
        logic p;
        l = (len == 0 || len > 8) ? 8 : len;
        for (int r = 0; r <= rep; r++) begin
            p = 1'b0;
            for (int i = l - 1; i >= 0; i--) begin
                push(1'b1, pat[i], 1'b0, 1'b1, 1'b0);
                p = p ^ pat[i];
            end
`ifdef SEQ_TX_PARITY_EN
            push(1'b1, p, 1'b0, 1'b1, 1'b0);
`endif
            if (r < rep)
                for (int g = 0; g < GAP; g++)
                    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    // Wait (bounded) for ready, present one request, then scramble the inputs.
    task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                        output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (start_ready) ok = 1'b1;
        end
        if (ok) begin
            start_valid = 1'b1;
            pat_in = p; len_in = l; rep_in = r;
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            pat_in = ~p; len_in = 4'd1; rep_in = 4'd7;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        tests++; if (x_out !== 1'b0) begin fails++; $display("FAIL reset_x_out: got %b required 0", x_out); end
        tests++; if (x_vld !== 1'b0) begin fails++; $display("FAIL reset_x_vld: got %b required 0", x_vld); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", start_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_stream(input string name, input logic [7:0] p,
                               input logic [3:0] l, input logic [3:0] r);
        bit ok;
        int cyc;
        logic [4:0] e, got;
        send(p, l, r, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL %s_accept: start_ready stayed 0, required 1", name); end
        push_frame(p, int'(l), int'(r));
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            @(negedge clk);
            got = {x_vld, x_out, done, busy, start_ready};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL %s cyc %0d: got vld/x/done/busy/rdy=%b required %b", name, cyc, got, e);
            end
        end
        @(negedge clk);
        tests++;
        if (start_ready !== 1'b1) begin fails++; $display("FAIL %s_ready_after: got %b required 1", name, start_ready); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [4:0] e, got;
        @(negedge clk);
        start_valid = 1'b1;
        pat_in = 8'h96; len_in = 4'd4; rep_in = 4'd2;
        @(posedge clk);
        #1;
        pat_in = 8'h3C; len_in = 4'd5; rep_in = 4'd0;   // valid stays high throughout
        push_frame(8'h96, 4, 2);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            @(negedge clk);
            got = {x_vld, x_out, done, busy, start_ready};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL b2b_first cyc %0d: got vld/x/done/busy/rdy=%b required %b", cyc, got, e);
            end
        end
        @(negedge clk);
        tests++;
        if ({busy, start_ready} !== 2'b01) begin
            fails++; $display("FAIL b2b_idle: got busy/rdy=%b required 01", {busy, start_ready});
        end
        @(posedge clk);
        #1 start_valid = 1'b0;
        push_frame(8'h3C, 5, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            @(negedge clk);
            got = {x_vld, x_out, done, busy, start_ready};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL b2b_second cyc %0d: got vld/x/done/busy/rdy=%b required %b", cyc, got, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [4:0] e, got;
        send(8'b1011_0010, 4'd8, 4'd0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rmid_accept: start_ready stayed 0, required 1"); end
        push_frame(8'b1011_0010, 8, 0);
        for (int c = 1; c <= 4; c++) begin
            e = sb.pop_front();
            @(negedge clk);
            got = {x_vld, x_out, done, busy, start_ready};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL rmid_pre cyc %0d: got vld/x/done/busy/rdy=%b required %b", c, got, e);
            end
        end
        sb.delete();
        #1 rst = 1'b0;   // mid-cycle, no clock edge involved
        #1;
        tests++;
        if ({x_vld, x_out, busy, start_ready} !== 4'b0001) begin
            fails++; $display("FAIL rmid_async: got vld/x/busy/rdy=%b required 0001", {x_vld, x_out, busy, start_ready});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0) begin fails++; $display("FAIL rmid_no_done: got %b required 0", done); end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        test_stream("rmid_fresh", 8'h6D, 4'd8, 4'd0);
    endtask

    // Overlapping "1011" detector fed by the line; pattern yields one hit per frame.
    task automatic test_loopback;
        bit ok, seen_done;
        int s, z_cnt;
        send(8'b1011_0000, 4'd8, 4'd3, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL loop_accept: start_ready stayed 0, required 1"); end
        s = 0; z_cnt = 0; seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge clk);
            if (x_vld === 1'b1) begin
                case (s)
                    0: s = x_out ? 1 : 0;
                    1: s = x_out ? 1 : 2;
                    2: s = x_out ? 3 : 0;
                    default: begin
                        if (x_out) begin z_cnt++; s = 1; end
                        else s = 2;
                    end
                endcase
            end
            if (done === 1'b1) seen_done = 1'b1;
        end
        tests++;
        if (!seen_done) begin fails++; $display("FAIL loop_done: no done within 200 cycles"); end
        tests++;
        if (z_cnt != 4) begin fails++; $display("FAIL loop_z_count: got %0d required 4", z_cnt); end
    endtask

    initial begin
        start_valid = 1'b0;
        pat_in = '0; len_in = '0; rep_in = '0;
        test_reset;
        test_stream("full_len0", 8'b1011_0010, 4'd0, 4'd0);
        test_stream("gap_len3", 8'h05, 4'd3, 4'd1);
        test_stream("len_clamp", 8'hC9, 4'd12, 4'd0);
        test_stream("rep_max", 8'hA5, 4'd2, 4'd15);
        test_stream("parity_even", 8'b1011_0010, 4'd8, 4'd0);
        test_stream("parity_odd", 8'b1011_0011, 4'd8, 4'd0);
        test_back_to_back;
        test_reset_mid;
        test_loopback;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial stimulus transmitter for the single-bit sequence-detector FSMs in this codebase.
- Accepts a bit pattern, a length and a repeat count through a valid/ready start handshake.
- Emits the pattern MSB-first, one bit per clock, on a serial line that feeds a detector's x input.
- Marks frame bits with a valid strobe, inserts a fixed idle gap between repetitions, and pulses done at the end.

Parameters:
- PAT_W, 8, maximum pattern length in bits (≥2).
- CNT_W, 4, width of the repeat-count input.
- GAP_LEN, 2, idle cycles between repetitions. 0 means back-to-back frames.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_valid  in  1  request to transmit.
- start_ready  out  1  block idle, request can be accepted.
- pat_in  in  PAT_W  pattern. Active bits are [len-1:0].
- len_in  in  $clog2(PAT_W+1)  frame length in bits. 0 or any value >PAT_W is treated as PAT_W.
- rep_in  in  CNT_W  frame is sent rep_in+1 times.
- x_out  out  1  serial data to the detector.
- x_vld  out  1  x_out carries a frame bit this cycle.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset: rst low forces state IDLE immediately; the clock is not required.
  - Reset values: x_out=0, x_vld=0, busy=0, done=0, all counters 0.
  - start_ready = (state==IDLE), so it reads 1 during reset.
- Handshake: a request is accepted on a rising edge where start_valid & start_ready.
  - On acceptance, pat_in, effective len and rep_in are latched. Later changes on these inputs are ignored.
  - start_valid while busy is ignored; nothing is queued.
- States: IDLE, SHIFT, GAP, PAR (only with the macro), DONE.
  - IDLE -> SHIFT on acceptance.
  - SHIFT: every cycle, x_out = latched pat[bit_idx] and x_vld=1. bit_idx starts at len-1 and decrements.
  - SHIFT, after bit 0:
    - to PAR if the macro is defined;
    - else to GAP if repetitions remain and GAP_LEN>0;
    - else to SHIFT (bit_idx reloads to len-1) if repetitions remain;
    - else to DONE.
  - GAP: x_out=0, x_vld=0 for exactly GAP_LEN cycles, then SHIFT with bit_idx=len-1.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Outputs x_out, x_vld and done are registered.
- Latency: the first bit appears in the cycle after the accepting edge.
- Total cycles from the accepting edge to done high = (rep+1)*len + rep*GAP_LEN + 1, where rep and len are the latched values; add rep+1 with the macro.
- The repetition counter is CNT_W bits. rep_in at all-ones sends 2^CNT_W frames with no overflow: the counter counts down and stops at 0.
- busy=1 in SHIFT, GAP and PAR.
- A new request is accepted in the cycle after DONE, i.e. in IDLE.
- Reset mid-frame: the line drops to x_out=0, x_vld=0 at once. No done pulse is generated, and the frame is not resumed.

Optional Feature:
- Macro SEQ_TX_PARITY_EN.
- Defined: after bit 0 of each frame the block enters PAR for one cycle. In PAR, x_out = XOR of the len active bits (even parity) and x_vld=1. Then the normal GAP/SHIFT/DONE decision is made.
- Undefined: no PAR state and no parity logic; frames are exactly len bits.

Decomposition:
- Package seq_tx_pkg holds:
  - the state typedef (IDLE, SHIFT, GAP, PAR, DONE), 3-bit encoding;
  - the GAP_LEN default;
  - the function for effective length (maps 0 and >PAT_W to PAT_W).
- One sub-module, seq_tx_shreg: loadable PAT_W-bit register with bit_idx down-counter and a last-bit flag. The top level holds the FSM and the repeat/gap counters.

Test Plan:
- PAT_W=8, pat=8'b1011_0010, len=0, rep=0 -> x_out 1,0,1,1,0,0,1,0 with x_vld=1 on cycles 1-8 after accept. done on cycle 9. start_ready back to 1 on cycle 10.
- pat=8'h05, len=3, rep=1, GAP_LEN=2 -> 1,0,1, two x_vld=0 cycles with x_out=0, then 1,0,1. done 1 cycle later (total 9 cycles).
- start_valid held high through a rep=2 transfer -> only one acceptance. The next acceptance occurs on the cycle start_ready returns high.
- rst asserted on the 4th bit of an 8-bit frame -> x_vld=0 and busy=0 asynchronously, no done pulse. After release, a fresh request transmits correctly from its MSB.
- SEQ_TX_PARITY_EN defined:
  - pat=8'b1011_0010 (four 1s), len=8 -> 9th bit 0;
  - pat=8'b1011_0011 (five 1s) -> 9th bit 1;
  - done on cycle 10.
- Loopback into the 4-state sequence detector: len=8, rep=3 with the pattern chosen to raise z once per frame -> detector flags z exactly 4 times.
